exec_mem_buffer: RTL and testbench

- Parametrised elastic pipeline buffer carrying execute-stage results (payload plus per-instruction exception flags) into the memory stage.
- Replaces the single fixed execute/memory register with a DEPTH-entry FIFO that uses a valid/ready handshake, pipeline flush and precise-exception blocking.
- Also provides a prioritised exception summary and a stall performance counter.

---
 rtl/exec_mem_buffer.sv | 133 +++++++++++++
 tb/tb_exec_mem_buffer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/exec_mem_buffer.sv
// Elastic execute-to-memory pipeline buffer: circular FIFO with a valid/ready handshake,
// pipeline flush, precise-exception input blocking, exception summary and stall counter.
module exec_mem_buffer #(
  parameter int DATA_W    = 256,
  parameter int EXC_W     = 7,
  parameter int DEPTH     = 2,
  parameter int EXC_BLOCK = 1,
  parameter int CNT_W     = $clog2(DEPTH + 1),
  parameter int CODE_W    = $clog2(EXC_W)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_exc_any,
  output logic [CODE_W-1:0] out_exc_code,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              exc_pending,
  output logic [31:0]       stall_cycles
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  r_head, r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_stall;

  logic [DATA_W-1:0] w_slot_data [DEPTH];
  logic [EXC_W-1:0]  w_slot_exc  [DEPTH];
  logic [DEPTH-1:0]  w_slot_flag;
  logic              w_full, w_empty, w_pending, w_ready, w_push, w_pop;
  logic [PTR_W-1:0]  w_head_next, w_tail_next;
  logic [EXC_W-1:0]  w_out_exc;
  logic [CODE_W-1:0] w_code;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_pending = |w_slot_flag;
  // Ready depends only on held state, never on this cycle's handshake inputs.
  assign w_ready   = !w_full && !((EXC_BLOCK != 0) && w_pending);
  assign w_push    = in_valid && w_ready && !flush;
  assign w_pop     = !w_empty && out_ready && !flush;

  assign w_head_next = (r_head == LAST_PTR) ? '0 : r_head + PTR_W'(1);
  assign w_tail_next = (r_tail == LAST_PTR) ? '0 : r_tail + PTR_W'(1);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [DATA_W-1:0] r_data;
      logic [EXC_W-1:0]  r_exc;
      logic              r_flag;
      logic              w_wr, w_rd;

      assign w_wr = w_push && (r_tail == PTR_W'(gi));
      assign w_rd = w_pop && (r_head == PTR_W'(gi));

      // r_flag caches |exc for the slot while it is occupied, so the pending summary is a DEPTH-wide OR.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_data <= '0;
          r_exc  <= '0;
          r_flag <= 1'b0;
        end else begin
          if (w_wr) begin
            r_data <= in_data;
            r_exc  <= in_exc;
          end
          if (flush)     r_flag <= 1'b0;
          else if (w_wr) r_flag <= |in_exc;
          else if (w_rd) r_flag <= 1'b0;
        end
      end

      assign w_slot_data[gi] = r_data;
      assign w_slot_exc[gi]  = r_exc;
      assign w_slot_flag[gi] = r_flag;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= w_tail_next;
      if (w_pop)  r_head <= w_head_next;
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Counts stalls in flush cycles too; saturates instead of wrapping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_stall <= '0;
    else if (in_valid && !w_ready && (r_stall != 32'hFFFF_FFFF))
      r_stall <= r_stall + 32'd1;
  end

  assign w_out_exc = w_empty ? '0 : w_slot_exc[r_head];

  always_comb begin
    w_code = '0;
    for (int i = EXC_W - 1; i >= 0; i--) begin
      if (w_out_exc[i]) w_code = CODE_W'(i);
    end
  end

  assign in_ready     = w_ready;
  assign out_valid    = !w_empty;
  assign out_data     = w_empty ? '0 : w_slot_data[r_head];
  assign out_exc      = w_out_exc;
  assign out_exc_any  = |w_out_exc;
  assign out_exc_code = w_code;
  assign count        = r_count;
  assign full         = w_full;
  assign exc_pending  = w_pending;
  assign stall_cycles = r_stall;
endmodule

// File: tb/tb_exec_mem_buffer.sv
// Randomized bench for exec_mem_buffer (DEPTH=3) checked each cycle against a queue-based model.
module tb_exec_mem_buffer;
  localparam int DW = 32;
  localparam int EW = 7;
  localparam int DEPTH = 3;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int XW = $clog2(EW);

  typedef struct packed {
    logic [DW-1:0] d;
    logic [EW-1:0] e;
  } ent_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid, in_ready, flush, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [EW-1:0] in_exc, out_exc;
  logic          out_exc_any, full, exc_pending;
  logic [XW-1:0] out_exc_code;
  logic [CW-1:0] count;
  logic [31:0]   stall_cycles;

  ent_t q[$];
  int   m_stall;
  int   n_vec = 0;
  int   n_err = 0;

  exec_mem_buffer #(.DATA_W(DW), .EXC_W(EW), .DEPTH(DEPTH), .EXC_BLOCK(1)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_exc(in_exc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_exc(out_exc),
    .out_exc_any(out_exc_any), .out_exc_code(out_exc_code), .count(count),
    .full(full), .exc_pending(exc_pending), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic m_pending();
    logic p = 1'b0;
    foreach (q[i]) if (q[i].e != '0) p = 1'b1;
    return p;
  endfunction

  function automatic logic m_ready();
    return (q.size() < DEPTH) && !m_pending();
  endfunction

  task automatic compare_all();
    logic [DW-1:0] ed;
    logic [EW-1:0] ee;
    int code;
    ed = (q.size() != 0) ? q[0].d : '0;
    ee = (q.size() != 0) ? q[0].e : '0;
    code = 0;
    for (int i = 0; i < EW; i++) begin
      if (ee[i]) begin
        code = i;
        break;
      end
    end
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("out_data", 64'(out_data), 64'(ed));
    chk("out_exc", 64'(out_exc), 64'(ee));
    chk("out_exc_any", 64'(out_exc_any), 64'(ee != '0));
    chk("out_exc_code", 64'(out_exc_code), 64'(code));
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("exc_pending", 64'(exc_pending), 64'(m_pending()));
    chk("in_ready", 64'(in_ready), 64'(m_ready()));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
  endtask

  task automatic model_update();
    logic rdy, push, pop;
    rdy = m_ready();
    if (in_valid && !rdy) m_stall++;
    if (flush) begin
      q.delete();
    end else begin
      push = in_valid && rdy;
      pop  = (q.size() != 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{d: in_data, e: in_exc});
    end
  endtask

  task automatic step(input logic iv, input logic [DW-1:0] d, input logic [EW-1:0] e,
                      input logic fl, input logic orr);
    in_valid = iv; in_data = d; in_exc = e; flush = fl; out_ready = orr;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    resetn = 1'b0; in_valid = 0; in_data = '0; in_exc = '0; flush = 0; out_ready = 0;
    m_stall = 0;
    repeat (2) @(negedge clk);
    compare_all();
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    resetn = 1'b1;

    // fill, stall while full, then pop with in_valid held
    step(1, 32'hA, '0, 0, 0);
    chk("pin_first_data", 64'(out_data), 64'hA);
    chk("pin_first_count", 64'(count), 64'd1);
    step(1, 32'hB, '0, 0, 0);
    step(1, 32'hC, '0, 0, 0);
    chk("pin_full", 64'(full), 64'd1);
    chk("pin_full_ready", 64'(in_ready), 64'd0);
    step(1, 32'hD, '0, 0, 0);
    step(1, 32'hD, '0, 0, 0);
    chk("pin_stall2", 64'(stall_cycles), 64'd2);
    step(1, 32'hD, '0, 0, 1);
    chk("pin_pop_only_count", 64'(count), 64'd2);
    chk("pin_pop_head_b", 64'(out_data), 64'hB);
    chk("pin_stall3", 64'(stall_cycles), 64'd3);
    step(0, '0, '0, 0, 1);
    step(0, '0, '0, 0, 1);
    chk("pin_drained", 64'(count), 64'd0);

    // exception blocks further input until popped
    step(1, 32'hE, 7'b0100100, 0, 0);
    chk("pin_exc_code", 64'(out_exc_code), 64'd2);
    chk("pin_exc_any", 64'(out_exc_any), 64'd1);
    chk("pin_exc_block", 64'(in_ready), 64'd0);
    step(1, 32'hF, '0, 0, 1);
    chk("pin_exc_popped_ready", 64'(in_ready), 64'd1);
    chk("pin_exc_popped_count", 64'(count), 64'd0);

    // flush beats push and pop
    step(1, 32'h11, '0, 0, 0);
    step(1, 32'h22, '0, 0, 0);
    step(1, 32'h99, 7'h01, 1, 1);
    chk("pin_flush_count", 64'(count), 64'd0);
    chk("pin_flush_valid", 64'(out_valid), 64'd0);

    // back-to-back push/pop at count 1 over the non-power-of-two wrap
    step(1, 32'h100, '0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step(1, 32'h100 + 32'(i), '0, 0, 1);
      chk("pin_b2b_count", 64'(count), 64'd1);
      chk("pin_b2b_data", 64'(out_data), 64'h100 + 64'(i));
    end

    for (int it = 0; it < 1500; it++) begin
      step($urandom_range(0, 3) != 0, $urandom,
           ($urandom_range(0, 5) == 0) ? EW'($urandom_range(1, 127)) : '0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
      if (it == 700 || it == 1200) begin
        // asynchronous reset between clock edges
        #2;
        in_valid = 0; flush = 0; out_ready = 0;
        resetn = 1'b0;
        q.delete();
        m_stall = 0;
        #1;
        compare_all();
        chk("async_rst_stall", 64'(stall_cycles), 64'd0);
        chk("async_rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        resetn = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
